dmem_arbiter: RTL and testbench



---
 rtl/dmem_defs.sv | 14 +
 rtl/dmem_arbiter_rr_pick2.sv | 24 ++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_defs.sv
// Shared opcodes and FSM state encoding for the data-memory arbiter.
package dmem_defs;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_NOP = 6'b000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker; one port can be masked out so a finishing
// winner cannot immediately re-win against the other port.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  input  logic excl_en,
  input  logic excl_idx,
  output logic valid,
  output logic winner
);

  logic r0;
  logic r1;

  always_comb begin
    r0     = req0 & ~(excl_en & ~excl_idx);
    r1     = req1 & ~(excl_en & excl_idx);
    valid  = r0 | r1;
    // On a tie the port that was not served last goes first
    winner = (r0 & r1) ? ~last_served : r1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the
// load/store stage (port 0) and the watermark engine (port 1).
module dmem_arbiter
  import dmem_defs::*;
#(
  parameter int DEPTH  = 33,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              err0,
  output logic              ack1,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic [5:0]        mem_opcode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_Rt,
  input  logic [31:0]       mem_out
);

  state_t              state_q;
  state_t              state_d;
  logic                last_served_q;
  logic                cur_port_q;
  logic                cur_we_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [31:0]         cur_wdata_q;
  logic [31:0]         rdata_q;
  logic                cur_oor;
  logic                pick_valid;
  logic                pick_winner;
  logic                latch_new;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_served (last_served_q),
    .excl_en     (state_q == DONE),
    .excl_idx    (cur_port_q),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  assign cur_oor   = (cur_addr_q >= ADDR_W'(DEPTH));
  assign latch_new = pick_valid && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_valid ? ISSUE : IDLE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = pick_valid ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch; mem_addr/mem_Rt come straight from here so they hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      last_served_q <= 1'b1;
      cur_port_q    <= 1'b0;
      cur_we_q      <= 1'b0;
      cur_addr_q    <= '0;
      cur_wdata_q   <= '0;
      rdata_q       <= '0;
    end else begin
      if (latch_new) begin
        cur_port_q  <= pick_winner;
        cur_we_q    <= pick_winner ? we1 : we0;
        cur_addr_q  <= pick_winner ? addr1 : addr0;
        cur_wdata_q <= pick_winner ? wdata1 : wdata0;
      end
      if (state_q == ISSUE) rdata_q <= cur_oor ? 32'd0 : mem_out;
      if (state_q == DONE)  last_served_q <= cur_port_q;
    end
  end

  always_comb begin
    mem_opcode = OP_NOP;
    ack0       = 1'b0;
    ack1       = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    if (state_q == ISSUE && !cur_oor) mem_opcode = cur_we_q ? OP_SW : OP_LW;
    if (state_q == DONE) begin
      ack0 = ~cur_port_q;
      ack1 = cur_port_q;
      err0 = ~cur_port_q & cur_oor;
      err1 = cur_port_q & cur_oor;
    end
  end

  assign mem_addr = cur_addr_q;
  assign mem_Rt   = cur_wdata_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural falling-edge data memory.
module tb_dmem_arbiter;
  import dmem_defs::*;

  localparam int DEPTH = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata;
  logic [5:0]  mem_opcode;
  logic [31:0] mem_addr, mem_Rt, mem_out;

  logic [31:0] mem [DEPTH];
  logic [31:0] expmem [DEPTH];
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .err0(err0), .ack1(ack1), .err1(err1),
    .rdata(rdata), .mem_opcode(mem_opcode), .mem_addr(mem_addr),
    .mem_Rt(mem_Rt), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Memory stores on the falling edge and reads combinationally
  always @(negedge clk) begin
    if (mem_opcode == OP_SW && mem_addr < DEPTH) mem[mem_addr[5:0]] <= mem_Rt;
  end

  always_comb begin
    mem_out = 32'h0BAD_0BAD;
    if (mem_addr < DEPTH) mem_out = mem[mem_addr[5:0]];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic rq, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin
      req0 = rq; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = rq; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    int both;
    int acks1;
    int wait1;
    int gap;
    logic pending1;
    logic [31:0] bad;

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hDEAD_BEEF;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick; tick;
    rst = 1'b0;
    checkOutput("reset_ack0", ack0, 0);
    checkOutput("reset_ack1", ack1, 0);
    checkOutput("reset_err", {err0, err1}, 0);
    checkOutput("reset_rdata", rdata, 0);
    checkOutput("reset_opcode", mem_opcode, OP_NOP);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_rt", mem_Rt, 0);

    $display("[TB] single load");
    applyStimulus(0, 1, 0, 5, 0);
    tick;
    checkOutput("ld_issue_op", mem_opcode, 6'b100011);
    checkOutput("ld_issue_addr", mem_addr, 5);
    checkOutput("ld_issue_noack", ack0, 0);
    tick;
    checkOutput("ld_ack0", ack0, 1);
    checkOutput("ld_rdata", rdata, 32'hDEAD_BEEF);
    checkOutput("ld_err0", err0, 0);
    checkOutput("ld_done_op", mem_opcode, OP_NOP);
    applyStimulus(0, 0, 0, 5, 0);
    tick;
    checkOutput("ld_idle_ack0", ack0, 0);
    checkOutput("ld_idle_addr_hold", mem_addr, 5);

    $display("[TB] store then load on port 1");
    applyStimulus(1, 1, 1, 7, 32'h1234_5678);
    tick;
    checkOutput("st_issue_op", mem_opcode, 6'b101011);
    checkOutput("st_issue_rt", mem_Rt, 32'h1234_5678);
    tick;
    checkOutput("st_ack1", ack1, 1);
    checkOutput("st_ack0", ack0, 0);
    applyStimulus(1, 1, 0, 7, 0);
    tick;
    checkOutput("st_own_req_ignored", ack1, 0);
    checkOutput("st_idle_op", mem_opcode, OP_NOP);
    tick;
    checkOutput("ld7_issue_op", mem_opcode, OP_LW);
    tick;
    checkOutput("ld7_ack1", ack1, 1);
    checkOutput("ld7_rdata", rdata, 32'h1234_5678);
    checkOutput("mem7_direct", mem[7], 32'h1234_5678);
    applyStimulus(1, 0, 0, 0, 0);
    tick;

    $display("[TB] contention");
    applyStimulus(0, 1, 0, 2, 0);
    applyStimulus(1, 1, 0, 3, 0);
    tick;
    checkOutput("tie_issue_addr", mem_addr, 2);
    tick;
    checkOutput("tie_ack0", ack0, 1);
    checkOutput("tie_ack1_low", ack1, 0);
    checkOutput("tie_rdata0", rdata, 32'h1000_0002);
    applyStimulus(0, 1, 0, 4, 0);
    tick;
    checkOutput("tie_loser_issue_addr", mem_addr, 3);
    checkOutput("tie_loser_issue_op", mem_opcode, OP_LW);
    tick;
    checkOutput("tie_ack1", ack1, 1);
    checkOutput("tie_rdata1", rdata, 32'h1000_0003);
    applyStimulus(1, 0, 0, 0, 0);
    tick;
    checkOutput("rr_port0_issue_addr", mem_addr, 4);
    checkOutput("rr_port0_noack", {ack0, ack1}, 0);
    tick;
    checkOutput("rr_port0_ack", ack0, 1);
    checkOutput("rr_port0_rdata", rdata, 32'h1000_0004);
    applyStimulus(0, 0, 0, 0, 0);
    tick;

    $display("[TB] address boundaries");
    applyStimulus(0, 1, 0, 32, 0);
    tick;
    checkOutput("last_word_op", mem_opcode, OP_LW);
    tick;
    checkOutput("last_word_err0", {ack0, err0}, 2'b10);
    checkOutput("last_word_rdata", rdata, 32'h1000_0020);
    applyStimulus(0, 1, 1, 33, 32'hFFFF_FFFF);
    tick; tick;
    checkOutput("oor_issue_op", mem_opcode, OP_NOP);
    checkOutput("oor_issue_addr", mem_addr, 33);
    tick;
    checkOutput("oor_ack_err0", {ack0, err0}, 2'b11);
    checkOutput("oor_rdata", rdata, 0);
    checkOutput("oor_done_op", mem_opcode, OP_NOP);
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    for (int i = 0; i < DEPTH; i++) expmem[i] = 32'h1000_0000 + i;
    expmem[5] = 32'hDEAD_BEEF;
    expmem[7] = 32'h1234_5678;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== expmem[i]) bad++;
    checkOutput("oor_mem_untouched", bad, 0);
    applyStimulus(1, 1, 0, 32'hFFFF_FFF0, 0);
    tick;
    checkOutput("oor_big_issue_op", mem_opcode, OP_NOP);
    tick;
    checkOutput("oor_big_ack_err1", {ack1, err1}, 2'b11);
    checkOutput("oor_big_rdata", rdata, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick;

    $display("[TB] reset mid-transaction");
    applyStimulus(0, 1, 0, 5, 0);
    tick;
    checkOutput("rst_ld_issue_op", mem_opcode, OP_LW);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    tick;
    checkOutput("rst_ld_noack", {ack0, ack1, err0, err1}, 0);
    checkOutput("rst_ld_rdata", rdata, 0);
    checkOutput("rst_ld_outs", {mem_opcode, mem_addr, mem_Rt}, 0);
    rst = 1'b0;
    applyStimulus(1, 1, 1, 9, 32'hCAFE_F00D);
    tick;
    checkOutput("rst_st_issue_op", mem_opcode, OP_SW);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    tick;
    checkOutput("rst_st_noack", ack1, 0);
    checkOutput("rst_st_committed", mem[9], 32'hCAFE_F00D);
    rst = 1'b0;
    tick;

    $display("[TB] port 0 saturating, port 1 periodic");
    both = 0;
    acks1 = 0;
    wait1 = 0;
    gap = 1;
    pending1 = 1'b0;
    applyStimulus(0, 1, 0, 1, 0);
    for (int c = 0; c < 60; c++) begin
      if (!pending1 && gap == 0) begin
        applyStimulus(1, 1, 0, c % 8, 0);
        pending1 = 1'b1;
        wait1 = 0;
      end
      tick;
      if (ack0 && ack1) both++;
      if (ack0) addr0 = (addr0 + 1) & 32'd7;
      if (pending1) begin
        wait1++;
        if (ack1) begin
          checkOutput("starve_latency_le4", 32'(wait1 <= 4), 1);
          acks1++;
          pending1 = 1'b0;
          applyStimulus(1, 0, 0, 0, 0);
          gap = acks1 % 3;
        end else if (wait1 > 6) begin
          checkOutput("starve_timeout_ack1", ack1, 1);
          pending1 = 1'b0;
          applyStimulus(1, 0, 0, 0, 0);
          gap = 1;
        end
      end else if (gap > 0) begin
        gap--;
      end
    end
    checkOutput("no_dual_ack", both, 0);
    checkOutput("port1_served_count", 32'(acks1 >= 8), 1);
    applyStimulus(0, 0, 0, 0, 0);
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
